// File: rtl/main_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle MIPS main control unit.
// Holds the opcode constants, the ALUOp encodings (also consumed by the ALU
// control unit), the ALUSrcB / PCSource select encodings, the state
// enumeration and the packed control word driven by the output decoder.
package mips_ctrl_pkg;

  localparam int OPCODE_W = 6;
  localparam int STATE_W  = 4;

  // Opcodes (instr[31:26])
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  // ALUOp encodings; 2'b11 is reserved and never driven
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B input select
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    JUMP   = 4'd12
  } state_t;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
  } ctrl_word_t;

  // True for every opcode the FSM knows how to execute.
  function automatic logic opcodeSupported(input logic [OPCODE_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/main_ctrl_fsm_if.sv
// Control bus between the main control FSM and the datapath/memory.
// Carries the opcode from the instruction register, the memory ready
// handshake, every datapath enable/select and the debug state.
//
// Memory handshake: a request (memRead or memWrite with iOrD selecting the
// address) is held unchanged from its first cycle until the cycle in which
// imem_ready is 1; that cycle completes the access and the FSM moves on on
// the following clock edge. imem_ready has no effect in any other cycle.
//
// master: the control FSM.  slave: the datapath/memory side.
interface main_ctrl_fsm_if #(
  parameter int OPW = 6,
  parameter int STW = 4
);
  logic [OPW-1:0] iopcode;
  logic           imem_ready;
  logic           oPCWrite;
  logic           oPCWriteCond;
  logic           oIorD;
  logic           oMemRead;
  logic           oMemWrite;
  logic           oIRWrite;
  logic           oMemtoReg;
  logic           oRegDst;
  logic           oRegWrite;
  logic           oALUSrcA;
  logic [1:0]     oALUSrcB;
  logic [1:0]     oALUOp;
  logic [1:0]     oPCSource;
  logic           oillegal;
  logic [STW-1:0] ostate;

  modport master (
    input  iopcode, imem_ready,
    output oPCWrite, oPCWriteCond, oIorD, oMemRead, oMemWrite, oIRWrite,
           oMemtoReg, oRegDst, oRegWrite, oALUSrcA, oALUSrcB, oALUOp,
           oPCSource, oillegal, ostate
  );

  modport slave (
    output iopcode, imem_ready,
    input  oPCWrite, oPCWriteCond, oIorD, oMemRead, oMemWrite, oIRWrite,
           oMemtoReg, oRegDst, oRegWrite, oALUSrcA, oALUSrcB, oALUOp,
           oPCSource, oillegal, ostate
  );
endinterface

// File: rtl/main_ctrl_fsm_out_dec.sv
// Combinational output decoder for the main control FSM.
// Ports:
//   state    in   current FSM state
//   memReady in   memory completes the current access this cycle
//   ctrl     out  control word for the datapath
// All outputs are pure state decodes except PCWrite/IRWrite in FETCH, which
// are qualified by memReady so that a fetch with wait states still produces
// exactly one PC increment and one IR load.
module main_ctrl_out_dec
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       memReady,
  output ctrl_word_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.memRead  = 1'b1;
        ctrl.iOrD     = 1'b0;
        ctrl.aluSrcA  = 1'b0;
        ctrl.aluSrcB  = SRCB_FOUR;
        ctrl.aluOp    = ALUOP_ADD;
        ctrl.pcSource = PCSRC_ALU;
        ctrl.irWrite  = memReady;
        ctrl.pcWrite  = memReady;
      end
      DECODE: begin
        // Precompute the branch target into ALUOut
        ctrl.aluSrcA = 1'b0;
        ctrl.aluSrcB = SRCB_IMMSH2;
        ctrl.aluOp   = ALUOP_ADD;
      end
      MEMADR, ADDIEX: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALUOP_ADD;
      end
      MEMRD: begin
        ctrl.memRead = 1'b1;
        ctrl.iOrD    = 1'b1;
      end
      MEMWB: begin
        ctrl.regDst   = 1'b0;
        ctrl.memToReg = 1'b1;
        ctrl.regWrite = 1'b1;
      end
      MEMWR: begin
        ctrl.memWrite = 1'b1;
        ctrl.iOrD     = 1'b1;
      end
      EXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_RT;
        ctrl.aluOp   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.regDst   = 1'b1;
        ctrl.memToReg = 1'b0;
        ctrl.regWrite = 1'b1;
      end
      BRANCH: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluSrcB     = SRCB_RT;
        ctrl.aluOp       = ALUOP_SUB;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSource    = PCSRC_ALUOUT;
      end
      ADDIWB: begin
        ctrl.regDst   = 1'b0;
        ctrl.memToReg = 1'b0;
        ctrl.regWrite = 1'b1;
      end
      JUMP: begin
        ctrl.pcWrite  = 1'b1;
        ctrl.pcSource = PCSRC_JUMP;
      end
      default: ctrl = '0;  // IDLE and invalid encodings drive nothing
    endcase
  end

endmodule

// File: rtl/main_ctrl_fsm.sv
// Multicycle MIPS main control state machine.
// Ports:
//   iclk  in  system clock, rising edge
//   irst  in  synchronous active-high reset
//   bus   master side of main_ctrl_fsm_if: iopcode and imem_ready in; all
//         datapath enables/selects, oillegal and debug ostate out
// Holds the state register, the opcode captured in DECODE and the
// next-state logic; the control word comes from main_ctrl_out_dec.
module main_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input logic             iclk,
  input logic             irst,
  main_ctrl_fsm_if.master bus
);

  state_t         state;
  state_t         nextState;
  logic [OPW-1:0] opReg;
  ctrl_word_t     ctrl;

  // State register; reset abandons any pending access because IDLE drives
  // no write enables.
  always_ff @(posedge iclk) begin
    if (irst) state <= IDLE;
    else      state <= nextState;
  end

  // The opcode is sampled only in DECODE so later states do not depend on
  // the instruction register staying stable.
  always_ff @(posedge iclk) begin
    if (irst)                 opReg <= '0;
    else if (state == DECODE) opReg <= bus.iopcode;
  end

  always_comb begin
    nextState = IDLE;
    case (state)
      IDLE:   nextState = FETCH;
      FETCH:  nextState = bus.imem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.iopcode)
          OP_LW, OP_SW: nextState = MEMADR;
          OP_RTYPE:     nextState = EXEC;
          OP_BEQ:       nextState = BRANCH;
          OP_ADDI:      nextState = ADDIEX;
          OP_J:         nextState = JUMP;
          default:      nextState = FETCH;
        endcase
      end
      MEMADR: nextState = (opReg == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  nextState = bus.imem_ready ? MEMWB : MEMRD;
      MEMWB:  nextState = FETCH;
      MEMWR:  nextState = bus.imem_ready ? FETCH : MEMWR;
      EXEC:   nextState = ALUWB;
      ALUWB:  nextState = FETCH;
      BRANCH: nextState = FETCH;
      ADDIEX: nextState = ADDIWB;
      ADDIWB: nextState = FETCH;
      JUMP:   nextState = FETCH;
      default: nextState = IDLE;  // recover from invalid encodings
    endcase
  end

  main_ctrl_out_dec uOutDec (
    .state    (state),
    .memReady (bus.imem_ready),
    .ctrl     (ctrl)
  );

  assign bus.oPCWrite     = ctrl.pcWrite;
  assign bus.oPCWriteCond = ctrl.pcWriteCond;
  assign bus.oIorD        = ctrl.iOrD;
  assign bus.oMemRead     = ctrl.memRead;
  assign bus.oMemWrite    = ctrl.memWrite;
  assign bus.oIRWrite     = ctrl.irWrite;
  assign bus.oMemtoReg    = ctrl.memToReg;
  assign bus.oRegDst      = ctrl.regDst;
  assign bus.oRegWrite    = ctrl.regWrite;
  assign bus.oALUSrcA     = ctrl.aluSrcA;
  assign bus.oALUSrcB     = ctrl.aluSrcB;
  assign bus.oALUOp       = ctrl.aluOp;
  assign bus.oPCSource    = ctrl.pcSource;

  // Illegal opcode flag lasts only for the DECODE cycle that saw it.
  assign bus.oillegal = (state == DECODE) && !opcodeSupported(bus.iopcode);
  assign bus.ostate   = STW'(state);

endmodule

// File: doc/main_ctrl_fsm.md
Name: main_ctrl_fsm

Overview:
- Multicycle MIPS main control state machine.
- Decodes the instruction opcode once per instruction and steps through fetch, decode, execute, memory and writeback states.
- Drives every datapath enable, and drives oALUOp into the ALU control unit, which turns ALUOp plus funct into the ALU operation code.
- Sits between the instruction register (opcode source) and the datapath/memory; supports memory wait states through a ready handshake.

Parameters:
- OPW, 6, opcode width.
- STW, 4, state register width; all states must fit in it.

Ports:
- iclk  in  1  system clock, rising edge.
- irst  in  1  reset, synchronous, active-high.
- iopcode  in  6  instr[31:26] from the instruction register; sampled in DECODE only.
- imem_ready  in  1  memory completes the current access this cycle.
- oPCWrite  out  1  unconditional PC load.
- oPCWriteCond  out  1  PC load if ALU zero (beq).
- oIorD  out  1  0 = PC addresses memory; 1 = ALUOut addresses memory.
- oMemRead  out  1  memory read request.
- oMemWrite  out  1  memory write request.
- oIRWrite  out  1  instruction register load.
- oMemtoReg  out  1  register-file write data: 1 = MDR, 0 = ALUOut.
- oRegDst  out  1  destination register: 1 = rd, 0 = rt.
- oRegWrite  out  1  register-file write enable.
- oALUSrcA  out  1  ALU A input: 0 = PC, 1 = rs.
- oALUSrcB  out  2  ALU B input: 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- oALUOp  out  2  00 = add, 01 = subtract, 10 = use funct, 11 = reserved (never driven).
- oPCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- oillegal  out  1  one-cycle pulse for an unsupported opcode.
- ostate  out  STW  current state, for debug/trace.

Behaviour:
- Reset (synchronous, active-high): irst sampled high forces state IDLE. In IDLE every output is 0, including oALUOp = 00 and ostate = 0.
- Reset mid-instruction: aborts the instruction with no completion of the pending write. The next cycle is IDLE with oMemWrite = 0 and oRegWrite = 0.
- Leaving reset: the first cycle with irst low goes IDLE -> FETCH.
- Output timing: outputs are Moore decodes of the state register, except the qualified ones noted below.
- States and transitions:
  - IDLE -> FETCH.
  - FETCH: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00. IRWrite and PCWrite are asserted only in the cycle where imem_ready = 1. Stay in FETCH while imem_ready = 0; go to DECODE when it is 1. Each instruction gets exactly one PC increment and one IR load regardless of the number of wait cycles.
  - DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (branch target). Next state by opcode:
    - lw 100011 or sw 101011 -> MEMADR.
    - R-type 000000 -> EXEC.
    - beq 000100 -> BRANCH.
    - addi 001000 -> ADDIEX.
    - j 000010 -> JUMP.
    - any other opcode -> FETCH, with oillegal = 1 for that DECODE cycle.
  - MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Goes to MEMRD for lw, MEMWR for sw. The opcode is held in an internal register captured in DECODE; iopcode is not re-sampled.
  - MEMRD: MemRead = 1, IorD = 1. Stay while imem_ready = 0; go to MEMWB when it is 1.
  - MEMWB: RegDst = 0, MemtoReg = 1, RegWrite = 1 -> FETCH.
  - MEMWR: MemWrite = 1, IorD = 1. Stay while imem_ready = 0; go to FETCH when it is 1. MemWrite stays high for every wait cycle.
  - EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10 -> ALUWB.
  - ALUWB: RegDst = 1, MemtoReg = 0, RegWrite = 1 -> FETCH.
  - BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01 -> FETCH.
  - ADDIEX: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00 -> ADDIWB.
  - ADDIWB: RegDst = 0, MemtoReg = 0, RegWrite = 1 -> FETCH.
  - JUMP: PCWrite = 1, PCSource = 10 -> FETCH.
- Latency with no wait states, counting FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles. Each wait cycle adds one cycle.
- Invalid state encodings go to IDLE on the next clock.
- imem_ready outside FETCH, MEMRD and MEMWR is ignored.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - ALUOp encodings (ALUOP_ADD = 00, ALUOP_SUB = 01, ALUOP_FUNCT = 10), also used by the ALU control unit;
  - the state enumeration (IDLE = 0 ... JUMP);
  - the ALUSrcB and PCSource select encodings.
- One sub-module: main_ctrl_out_dec, a combinational map from state (plus imem_ready for the qualified outputs) to the control word.
- The FSM top holds the state register, the captured opcode and the next-state logic.

Test Plan:
- Reset, then lw, imem_ready held 1:
  - ostate goes IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH.
  - oALUOp = 00 in MEMADR; RegWrite = 1 and MemtoReg = 1 only in MEMWB.
- R-type, opcode 000000:
  - EXEC shows oALUOp = 10 and ALUSrcB = 00.
  - ALUWB shows RegDst = 1 and RegWrite = 1; total 4 cycles.
- beq, opcode 000100:
  - BRANCH cycle has oALUOp = 01, PCWriteCond = 1, PCSource = 01; returns to FETCH after 3 cycles.
- FETCH with imem_ready = 0 for 3 cycles, then 1:
  - oPCWrite and oIRWrite are each high for exactly 1 cycle (the 4th cycle); MemRead is high all 4 cycles.
- Illegal opcode 111111:
  - oillegal pulses 1 cycle in DECODE; next state is FETCH; no RegWrite or MemWrite observed.
- sw with irst asserted during MEMWR while imem_ready = 0:
  - next cycle ostate = IDLE and oMemWrite = 0; then FETCH after irst drops.
